sample_mem_multi: RTL and testbench

SAMPLE_MEM_MULTI -- requirements
Module: sample_mem_multi

---
 rtl/sample_mem_multi.sv | 112 +++++++++++
 tb/tb_sample_mem_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_mem_multi.sv
// Multi-channel keyed sample memory with a zeroing sweep and a strided read pointer.
// Define SAMPLE_MEM_MULTI_MON_EN to print a memory probe on every 16th event.
module sample_mem_multi #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NCH    = 2,
  parameter int unsigned STRIDE = 7,
  parameter int unsigned MATCH  = 45339
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic [NCH-1:0]        wr_valid,
  input  logic [NCH*DATA_W-1:0] wr_key,
  input  logic [NCH*DATA_W-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  clear_busy,
  output logic [DATA_W-1:0]     evt_cnt
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [15:0] MatchVal = 16'(MATCH);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                hit;
  logic [ADDR_W-1:0]   wr_addr [NCH];
  logic [DATA_W-1:0]   mem [DEPTH];

  assign hit = (ptr_q[15:0] == MatchVal);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ptr_d     = ptr_q;
    evt_cnt_d = evt_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
      end
      StRun: begin
        ptr_d = ptr_q + DATA_W'(STRIDE);
        if (hit) evt_cnt_d = evt_cnt_q + DATA_W'(1);
        if (clear_req) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Only the low key/pointer bits matter: the address is taken modulo DEPTH.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_addr[i] = wr_key[i*DATA_W +: ADDR_W] + ptr_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StClear;
      clr_idx_q  <= '0;
      ptr_q      <= '0;
      evt_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ptr_q      <= ptr_d;
      evt_cnt_q  <= evt_cnt_d;
      rd_valid_q <= (state_q == StRun);
      if (state_q == StRun) rd_data_q <= mem[ptr_q[ADDR_W-1:0]];
    end
  end

  // No reset on the array; ascending loop order lets the highest channel win a collision.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_idx_q] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_valid[i]) mem[wr_addr[i]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SAMPLE_MEM_MULTI_MON_EN
  always_ff @(posedge clk) begin
    if (reset && state_q == StRun && hit && evt_cnt_q[3:0] == 4'd0) begin
      $display("memory[%0d] = %0d", DEPTH / 2 - 1, mem[DEPTH/2-1]);
    end
  end
`endif

  assign clear_busy = (state_q == StClear);
  assign wr_ready   = (state_q == StRun);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign evt_cnt    = evt_cnt_q;

endmodule

// File: tb/tb_sample_mem_multi.sv
// Bench for sample_mem_multi: cycle model with read scoreboard, write vector table and
// hand sequences for sweep length, pointer wrap, clear request and mid-sweep reset.
module tb_sample_mem_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic [1:0]  wr_valid = '0;
  logic [63:0] wr_key = '0;
  logic [63:0] wr_data = '0;
  logic        wr_ready, rd_valid, clear_busy;
  logic [31:0] rd_data, evt_cnt;

  always #5 clk = ~clk;

  sample_mem_multi #(
    .DATA_W(32),
    .ADDR_W(8),
    .NCH   (2),
    .STRIDE(7),
    .MATCH (45339)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .wr_valid  (wr_valid),
    .wr_key    (wr_key),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .clear_busy(clear_busy),
    .evt_cnt   (evt_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_run;
  logic [7:0]  m_clr;
  logic [31:0] m_ptr, m_evt;
  logic [31:0] m_mem [256];
  bit          m_rv;
  logic [31:0] sb [$];

  typedef struct {
    logic [1:0]  v;
    logic [31:0] k0, d0, k1, d1;
    logic [7:0]  entry;
    logic [31:0] val;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [7];
  bit   seen [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_clr = '0;
    m_ptr = '0;
    m_evt = '0;
    m_rv  = 1'b0;
    sb.delete();
  endtask

  // Called just after a rising edge: drive, advance model, wait one edge, compare.
  task automatic cycle(input logic [1:0] v, input logic [31:0] k0, input logic [31:0] d0,
                       input logic [31:0] k1, input logic [31:0] d1, input logic clr);
    logic [31:0] s;
    logic [31:0] e;
    wr_valid  = v;
    wr_key    = {k1, k0};
    wr_data   = {d1, d0};
    clear_req = clr;
    if (m_run) begin
      sb.push_back(m_mem[m_ptr[7:0]]);
      if (v[0]) begin s = k0 + m_ptr; m_mem[s[7:0]] = d0; end
      if (v[1]) begin s = k1 + m_ptr; m_mem[s[7:0]] = d1; end
      if (m_ptr[15:0] == 16'd45339) m_evt++;
      m_ptr += 32'd7;
      m_rv = 1'b1;
      if (clr) begin
        m_run = 1'b0;
        m_clr = '0;
      end
    end else begin
      m_mem[m_clr] = '0;
      m_rv = 1'b0;
      if (m_clr == 8'd255) m_run = 1'b1;
      m_clr++;
    end
    @(posedge clk);
    #1;
    chk("clear_busy", clear_busy, !m_run);
    chk("wr_ready", wr_ready, m_run);
    chk("rd_valid", rd_valid, m_rv);
    chk("evt_cnt", evt_cnt, m_evt);
    if (m_rv) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_data: got %h want <no read queued>", rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
  endtask

  task automatic idle();
    cycle(2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    int edges;
    int nz;
    logic [7:0] a;

    // Applied on consecutive RUN cycles starting at ptr=14.
    tbl[0] = '{2'b01, 32'd5,          32'hDEAD, 32'd0,   32'd0,      8'd19,  32'hDEAD, 32'h0};
    tbl[1] = '{2'b11, 32'd3,          32'h11,   32'd3,   32'h22,     8'd24,  32'h22,   32'h0};
    tbl[2] = '{2'b10, 32'd0,          32'h0,    32'd100, 32'hCAFE,   8'd128, 32'hCAFE, 32'h0};
    tbl[3] = '{2'b01, 32'd250,        32'hBEEF, 32'd0,   32'd0,      8'd29,  32'hBEEF, 32'h0};
    tbl[4] = '{2'b11, 32'd0,          32'h1234, 32'd1,   32'h5678,   8'd43,  32'h5678, 32'h0};
    tbl[5] = '{2'b00, 32'd0,          32'h9999, 32'd0,   32'h9999,   8'd49,  32'h0,    32'h0};
    tbl[6] = '{2'b01, 32'hFFFF_FFFF,  32'hA5A5, 32'd0,   32'd0,      8'd55,  32'hA5A5, 32'h0};

    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear_busy", clear_busy, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_evt_cnt", evt_cnt, 32'h0);

    reset = 1'b1;
    edges = 0;
    do begin idle(); edges++; end while (clear_busy && edges < 300);
    chk("sweep_len", edges, 256);
    idle();
    chk("first_rd_valid", rd_valid, 1'b1);
    chk("first_rd_data", rd_data, 32'h0);

    edges = 0;
    while (m_ptr != 32'd14 && edges < 10) begin idle(); edges++; end
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].k0, tbl[i].d0, tbl[i].k1, tbl[i].d1, 1'b0);
      chk("tbl_prewrite_rd", rd_data, tbl[i].exp_rd);
    end
    for (int i = 0; i < 7; i++) seen[i] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      a = m_ptr[7:0];
      idle();
      for (int r = 0; r < 7; r++) begin
        if (!seen[r] && tbl[r].entry == a) begin
          chk("tbl_entry", rd_data, tbl[r].val);
          seen[r] = 1'b1;
        end
      end
    end
    for (int r = 0; r < 7; r++) chk("tbl_entry_read", seen[r], 1'b1);

    // ptr[15:0] hits 45339 after 6477 RUN cycles from zero.
    edges = 0;
    while (m_evt == 0 && edges < 8000) begin idle(); edges++; end
    chk("evt_once", evt_cnt, 32'd1);

    force dut.ptr_q = 32'hFFFF_FFFC;
    #1;
    release dut.ptr_q;
    m_ptr = 32'hFFFF_FFFC;
    cycle(2'b01, 32'd7, 32'h3333, '0, '0, 1'b0);
    chk("ptr_wrap", dut.ptr_q, 32'h3);
    idle();
    chk("wrap_rd", rd_data, 32'h3333);

    cycle(2'b00, '0, '0, '0, '0, 1'b1);
    edges = 0;
    do begin
      cycle(2'b11, 32'd3, 32'hFFFF, 32'd9, 32'hEEEE, 1'b1);
      edges++;
    end while (clear_busy && edges < 300);
    chk("clear_len", edges, 256);
    chk("ptr_kept", dut.ptr_q, m_ptr);
    chk("evt_kept", evt_cnt, 32'd1);
    nz = 0;
    for (int n = 0; n < 256; n++) begin
      idle();
      if (rd_data != 32'h0) nz++;
    end
    chk("all_zero", nz, 0);

    cycle(2'b00, '0, '0, '0, '0, 1'b1);
    edges = 0;
    while (m_clr != 8'd100 && edges < 300) begin idle(); edges++; end
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_clear_busy", clear_busy, 1'b1);
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    chk("mid_rst_evt_cnt", evt_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    edges = 0;
    do begin idle(); edges++; end while (clear_busy && edges < 300);
    chk("restart_len", edges, 256);
    idle();
    chk("restart_rd_valid", rd_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
